diff_scan_ctrl: RTL and testbench

DIFF_SCAN_CTRL -- requirements
Module: diff_scan_ctrl

---
 rtl/diff_scan_ctrl.sv | 63 ++++++
 tb/tb_diff_scan_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/diff_scan_ctrl.sv
// diff_scan_ctrl: serially reports each differing bit of a ^ b, lowest first, over a valid/ready handshake
module diff_scan_ctrl #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done,
  output logic [IDX_W:0]   count
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] residue, lowest;
  logic [IDX_W-1:0] enc;
  logic hs, single;
  // two's-complement trick isolates the lowest set bit
  assign lowest = residue & (~residue + 1'b1);
  assign single = (residue != '0) && ((residue & (residue - 1'b1)) == '0);
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) enc = enc | (lowest[i] ? IDX_W'(i) : '0);
  end
  assign busy       = state != IDLE;
  assign out_valid  = state == SCAN;
  assign done       = state == DONE;
  assign out_onehot = out_valid ? lowest : '0;
  assign out_idx    = out_valid ? enc : '0;
  assign out_last   = out_valid & single;
  assign hs         = out_valid & out_ready;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? ((a ^ b) != '0 ? SCAN : DONE) : IDLE) :
               state == SCAN ? (abort ? IDLE : (hs && out_last) ? DONE : SCAN) :
               IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      residue <= '0;
      count   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        residue <= a ^ b;
        count   <= '0;
      end else if (state == SCAN && abort) begin
        residue <= '0;
      end else if (hs) begin
        residue <= residue & ~lowest;
        count   <= count + 1'b1;
      end
    end
endmodule

// File: tb/tb_diff_scan_ctrl.sv
// tb_diff_scan_ctrl: table-driven, hand-written and random checks of diff_scan_ctrl against a bit-list model
module tb_diff_scan_ctrl;
  logic clk = 0, rst = 0, start = 0, abort = 0, out_ready = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, out_valid, out_last, done;
  logic [31:0] out_onehot;
  logic [4:0] out_idx;
  logic [5:0] count;
  int n_cmp = 0, n_err = 0;

  diff_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .abort(abort),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_idx(out_idx), .out_last(out_last),
    .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm, input int cnt);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_onehot"}, out_onehot, 0);
    chk({nm, "_idx"}, out_idx, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_count"}, count, cnt);
  endtask

  task automatic chk_beat(input string nm, input int idx, input logic last, input int cnt);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_idx"}, out_idx, idx);
    chk({nm, "_onehot"}, out_onehot, 32'd1 << idx);
    chk({nm, "_last"}, out_last, last);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_count"}, count, cnt);
  endtask

  // model: the ordered list of differing bit positions, consumed one per handshake
  task automatic scan(input logic [31:0] av, input logic [31:0] bv, input int hold, input int rdy_pct);
    logic [31:0] x;
    int q[$];
    int n, stall, cyc;
    x = av ^ bv;
    for (int i = 0; i < 32; i++) if (x[i]) q.push_back(i);
    n = 0; stall = 0; cyc = 0;
    @(negedge clk); start = 1; a = av; b = bv; out_ready = 0;
    @(negedge clk); start = 0;
    while (q.size() > 0) begin
      out_ready = (cyc >= hold) && (stall >= 3 || $urandom_range(99) < rdy_pct);
      chk_beat("beat", q[0], q.size() == 1, n);
      @(negedge clk); cyc++;
      if (out_ready) begin void'(q.pop_front()); n++; stall = 0; end
      else stall++;
    end
    out_ready = 0;
    chk("done_pulse", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 1);
    chk("done_count", count, n);
    @(negedge clk);
    chk_idle("after_done", n);
  endtask

  typedef struct {logic [31:0] a, b; int hold; int exp_cnt;} vec_t;
  vec_t tbl[6];

  initial begin
    logic [31:0] ra, rm;
    tbl[0] = '{32'h000000F0, 32'h00000030, 0, 2};
    tbl[1] = '{32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000000, 0, 32};
    tbl[3] = '{32'h80000001, 32'h00000000, 3, 2};
    tbl[4] = '{32'h00000001, 32'h00000000, 0, 1};
    tbl[5] = '{32'h00000000, 32'h80000000, 2, 1};
    #3 chk_idle("reset", 0);
    @(negedge clk); rst = 1;
    chk_idle("post_reset", 0);
    for (int i = 0; i < 6; i++) begin
      scan(tbl[i].a, tbl[i].b, tbl[i].hold, 100);
      chk("tbl_count", count, tbl[i].exp_cnt);
    end
    // abort while idle leaves everything alone
    @(negedge clk); abort = 1;
    @(negedge clk); abort = 0;
    chk_idle("idle_abort", 1);
    // start with new operands mid-scan is ignored
    @(negedge clk); start = 1; a = 32'h000000F0; b = 32'h00000030; out_ready = 0;
    @(negedge clk); start = 1; a = 32'h00000001; b = 0;
    chk_beat("ign0", 6, 0, 0);
    @(negedge clk); start = 0; out_ready = 1;
    chk_beat("ign1", 6, 0, 0);
    @(negedge clk);
    chk_beat("ign2", 7, 1, 1);
    @(negedge clk); out_ready = 0;
    chk("ign_done", done, 1);
    chk("ign_count", count, 2);
    @(negedge clk);
    chk_idle("ign_idle", 2);
    // abort after first beat beats a simultaneous handshake
    @(negedge clk); start = 1; a = 32'h0000000F; b = 0; out_ready = 1;
    @(negedge clk); start = 0;
    chk_beat("ab0", 0, 0, 0);
    @(negedge clk); abort = 1;
    chk_beat("ab1", 1, 0, 1);
    @(negedge clk); abort = 0; out_ready = 0;
    chk_idle("ab_idle", 1);
    @(negedge clk);
    chk_idle("ab_nodone", 1);
    // reset mid-scan clears outputs without a clock edge
    @(negedge clk); start = 1; a = 32'hFFFFFFFF; b = 0; out_ready = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    chk_beat("pre_rst", 1, 0, 1);
    #2 rst = 0;
    #1 chk_idle("rst_async", 0);
    @(negedge clk); rst = 1; start = 1; a = 32'h00000003; b = 0; out_ready = 1;
    @(negedge clk); start = 0;
    chk_beat("rst_first", 0, 0, 0);
    @(negedge clk);
    chk_beat("rst_second", 1, 1, 1);
    @(negedge clk); out_ready = 0;
    chk("rst_done", done, 1);
    @(negedge clk);
    chk_idle("rst_idle", 2);
    // random operand pairs with sparse differences and random backpressure
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rm = (i % 4 == 0) ? $urandom : $urandom & $urandom & $urandom;
      scan(ra, ra ^ rm, 0, 60);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
